// File: rtl/key_sched_engine.sv
// key_sched_engine: PRESENT-style round-key generator (80/128-bit key) with a valid/ready round-key stream.
// Define KSCHED_ZEROIZE_EN to clear the key register whenever the schedule ends (DONE or abort).
module key_sched_engine #(
    parameter int KEY_SIZE   = 80,
    parameter int NUM_ROUNDS = 31,
    parameter int IDX_W      = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_SIZE-1:0] key_in,
    input  logic                abort,
    output logic                ready,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [63:0]         rk_data,
    output logic [IDX_W-1:0]    rk_index,
    output logic                done
);
    // S-box nibbles packed LSB-first: entry x lives at bits [4x+3:4x]
    localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS + 1);
`ifdef KSCHED_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    logic [KEY_SIZE-1:0] r_key;
    logic [IDX_W-1:0]    r_cnt;
    logic                r_ready;
    logic                r_valid;
    logic                r_done;
    logic [KEY_SIZE-1:0] w_rot;
    logic [KEY_SIZE-1:0] w_next;
    logic [KEY_SIZE-1:0] w_exit_key;
    logic [4:0]          w_rc;
    logic                w_xfer;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    assign w_rot      = {r_key[KEY_SIZE-62:0], r_key[KEY_SIZE-1:KEY_SIZE-61]};
    assign w_rc       = 5'(r_cnt);
    assign w_xfer     = r_valid & rk_ready;
    assign w_exit_key = ZEROIZE ? '0 : r_key;

    generate
        if (KEY_SIZE == 128) begin : g_k128
            // 128-bit update: rotate, two S-boxes on the top byte, round counter into [66:62]
            always_comb begin
                w_next          = w_rot;
                w_next[127:124] = sbox(w_rot[127:124]);
                w_next[123:120] = sbox(w_rot[123:120]);
                w_next[66:62]   = w_rot[66:62] ^ w_rc;
            end
        end else begin : g_k80
            // 80-bit update: rotate, S-box on the top nibble, round counter into [19:15]
            always_comb begin
                w_next        = w_rot;
                w_next[79:76] = sbox(w_rot[79:76]);
                w_next[19:15] = w_rot[19:15] ^ w_rc;
            end
        end
    endgenerate

    // Control FSM; counter is kept at 0 outside RUN so it doubles as rk_index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_key   <= key_in;
                        r_cnt   <= IDX_W'(1);
                        r_ready <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_key   <= w_exit_key;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_valid <= 1'b0;
                    end else if (w_xfer) begin
                        if (r_cnt == LAST) begin
                            r_state <= S_DONE;
                            r_cnt   <= '0;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_key <= w_next;
                            r_cnt <= r_cnt + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_key   <= w_exit_key;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign rk_valid = r_valid;
    assign rk_data  = r_key[KEY_SIZE-1 -: 64];
    assign rk_index = r_cnt;
    assign done     = r_done;
endmodule
